// File: rtl/aes_spi_loader_if.sv
// rtl/aes_spi_loader_if.sv - serial load bus and committed-register outputs of the AES loader
interface aes_spi_loader_if #(
    parameter int NK = 8
);
    localparam int KEY_W = 32 * NK;
    localparam int BLK_W = 128;

    logic             cs_blk;
    logic             cs_key;
    logic             mosi;
    logic             miso;
    logic             core_busy;
    logic [BLK_W-1:0] blk_q;
    logic [KEY_W-1:0] key_q;
    logic             key_valid;
    logic             start;
    logic             frame_err;

    modport master (
        output cs_blk, cs_key, mosi, core_busy,
        input  miso, blk_q, key_q, key_valid, start, frame_err
    );

    modport slave (
        input  cs_blk, cs_key, mosi, core_busy,
        output miso, blk_q, key_q, key_valid, start, frame_err
    );
endinterface

// File: rtl/aes_spi_loader.sv
// rtl/aes_spi_loader.sv - serial block/key loader with loop-back readback and start handshake
module aes_spi_loader #(
    parameter int NK = 8
) (
    input  logic             clk,
    input  logic             rst,
    aes_spi_loader_if.slave  bus
);
    localparam int KEY_W = 32 * NK;
    localparam int BLK_W = 128;
    localparam int CW    = $clog2(KEY_W + 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLK_W - 1);
    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLK,
        S_KEY,
        S_DONE_BLK,
        S_DONE_KEY,
        S_ERR
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [BLK_W-1:0] sh_blk;
    logic [KEY_W-1:0] sh_key;
    logic [BLK_W-1:0] blk_r;
    logic [KEY_W-1:0] key_r;
    logic             key_valid_r;
    logic             blk_seen;
    logic             pending;
    logic             start_r;
    logic             frame_err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sh_blk      <= '0;
            sh_key      <= '0;
            blk_r       <= '0;
            key_r       <= '0;
            key_valid_r <= 1'b0;
            blk_seen    <= 1'b0;
            pending     <= 1'b0;
            start_r     <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            start_r     <= 1'b0;
            frame_err_r <= 1'b0;

            // Issue first; a commit on this same edge re-arms pending below.
            if (pending && !bus.core_busy) begin
                start_r <= 1'b1;
                pending <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!bus.cs_blk && bus.cs_key) begin
                        state <= S_BLK;
                    end else if (!bus.cs_key && bus.cs_blk) begin
                        state <= S_KEY;
                    end else if (!bus.cs_blk && !bus.cs_key) begin
                        frame_err_r <= 1'b1;
                        state       <= S_ERR;
                    end
                end

                S_BLK: begin
                    if (!bus.cs_key || bus.cs_blk) begin
                        sh_blk      <= blk_r;
                        cnt         <= '0;
                        frame_err_r <= 1'b1;
                        state       <= bus.cs_key ? S_IDLE : S_ERR;
                    end else begin
                        sh_blk <= {sh_blk[BLK_W-2:0], bus.mosi};
                        cnt    <= cnt + 1'b1;
                        if (cnt == BLK_LAST) begin
                            state <= S_DONE_BLK;
                        end
                    end
                end

                S_KEY: begin
                    if (!bus.cs_blk || bus.cs_key) begin
                        sh_key      <= key_r;
                        cnt         <= '0;
                        frame_err_r <= 1'b1;
                        state       <= bus.cs_blk ? S_IDLE : S_ERR;
                    end else begin
                        sh_key <= {sh_key[KEY_W-2:0], bus.mosi};
                        cnt    <= cnt + 1'b1;
                        if (cnt == KEY_LAST) begin
                            state <= S_DONE_KEY;
                        end
                    end
                end

                S_DONE_BLK: begin
                    if (!bus.cs_key) begin
                        frame_err_r <= 1'b1;
                        cnt         <= '0;
                        state       <= S_ERR;
                    end else if (bus.cs_blk) begin
                        blk_r    <= sh_blk;
                        blk_seen <= 1'b1;
                        cnt      <= '0;
                        if (key_valid_r) begin
                            pending <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end

                S_DONE_KEY: begin
                    if (!bus.cs_blk) begin
                        frame_err_r <= 1'b1;
                        cnt         <= '0;
                        state       <= S_ERR;
                    end else if (bus.cs_key) begin
                        key_r       <= sh_key;
                        key_valid_r <= 1'b1;
                        cnt         <= '0;
                        if (blk_seen) begin
                            pending <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end

                S_ERR: begin
                    // Drop whatever was shifted so the next frame reads back committed data.
                    sh_blk <= blk_r;
                    sh_key <= key_r;
                    cnt    <= '0;
                    if (bus.cs_blk && bus.cs_key) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.miso      = (state == S_BLK && !bus.cs_blk) ? sh_blk[BLK_W-1] :
                           (state == S_KEY && !bus.cs_key) ? sh_key[KEY_W-1] : 1'b0;
    assign bus.blk_q     = blk_r;
    assign bus.key_q     = key_r;
    assign bus.key_valid = key_valid_r;
    assign bus.start     = start_r;
    assign bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_aes_spi_loader.sv
// tb/tb_aes_spi_loader.sv - randomized self-checking bench for aes_spi_loader against a frame-level model
module tb_aes_spi_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    aes_spi_loader_if #(.NK(8)) bus();
    aes_spi_loader #(.NK(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_start  = 0;
    int n_ferr   = 0;
    int last_start_cyc = -1;
    int commit_cyc = 0;

    // frame-level reference state
    logic [127:0] m_blk;
    logic [255:0] m_key;
    logic         m_kv;
    logic         m_blk_seen;
    logic         m_pending;
    int           exp_start;
    int           exp_ferr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.start) begin
                n_start        = n_start + 1;
                last_start_cyc = cyc;
            end
            if (bus.frame_err) n_ferr = n_ferr + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.cs_blk = 1'b1; bus.cs_key = 1'b1; bus.mosi = 1'b0;
        idle(2);
        rst = 1'b0;
        m_blk = '0; m_key = '0; m_kv = 0; m_blk_seen = 0; m_pending = 0;
        n_start = 0; n_ferr = 0; exp_start = 0; exp_ferr = 0;
        idle(1);
    endtask

    task automatic do_frame(input bit is_key, input logic [255:0] data, input int nedges,
                            output logic [255:0] rx);
        int w;
        w  = is_key ? 256 : 128;
        rx = '0;
        @(negedge clk);
        if (is_key) bus.cs_key = 1'b0; else bus.cs_blk = 1'b0;
        for (int i = 0; i < nedges; i++) begin
            @(negedge clk);
            bus.mosi = (i < w) ? data[w-1-i] : 1'($urandom);
            if (i < w) rx[w-1-i] = bus.miso;
        end
        @(negedge clk);
        bus.cs_blk = 1'b1; bus.cs_key = 1'b1; bus.mosi = 1'b0;
        @(posedge clk);
        #1 commit_cyc = cyc;
    endtask

    task automatic run_frame(input string tag, input bit is_key, input logic [255:0] data,
                             input int nedges);
        logic [255:0] rx;
        logic [127:0] old_blk;
        bit           fire;
        int           w;
        w       = is_key ? 256 : 128;
        old_blk = m_blk;
        fire    = 0;
        do_frame(is_key, data, nedges, rx);
        if (nedges >= w) begin
            if (is_key) begin
                m_key = data;
                fire  = m_blk_seen;
                m_kv  = 1;
            end else begin
                m_blk      = data[127:0];
                fire       = m_kv;
                m_blk_seen = 1;
                check({tag, "_readback"}, rx[127:0], old_blk);
            end
        end else begin
            exp_ferr++;
        end
        if (fire) begin
            if (bus.core_busy) m_pending = 1;
            else exp_start++;
        end
        idle(3);
        check({tag, "_blk_q"}, bus.blk_q, m_blk);
        check({tag, "_key_q"}, bus.key_q, m_key);
        check({tag, "_key_valid"}, bus.key_valid, m_kv);
        check({tag, "_starts"}, n_start, exp_start);
        check({tag, "_frame_errs"}, n_ferr, exp_ferr);
        if (fire && !bus.core_busy) check({tag, "_start_lat"}, last_start_cyc, commit_cyc + 1);
    endtask

    initial begin
        logic [255:0] d;
        bus.cs_blk = 1'b1; bus.cs_key = 1'b1; bus.mosi = 1'b0; bus.core_busy = 1'b0;
        do_reset();

        check("rst_blk_q", bus.blk_q, 0);
        check("rst_key_q", bus.key_q, 0);
        check("rst_key_valid", bus.key_valid, 0);
        check("rst_start", bus.start, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_miso", bus.miso, 0);

        run_frame("key1", 1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 256);
        run_frame("blk1", 0, 256'h00112233445566778899aabbccddeeff, 128);
        run_frame("blk2", 0, 256'hffeeddccbbaa99887766554433221100, 128);

        run_frame("abort64", 0, {8{$urandom}}, 64);
        run_frame("after_abort", 0, {8{$urandom}}, 128);

        // cs_key asserted in the middle of a block frame
        @(negedge clk); bus.cs_blk = 1'b0;
        repeat (40) begin @(negedge clk); bus.mosi = 1'($urandom); end
        bus.cs_key = 1'b0;
        exp_ferr++;
        idle(4);
        check("collide_miso", bus.miso, 0);
        bus.cs_blk = 1'b1;
        idle(4);
        bus.cs_key = 1'b1;
        idle(3);
        check("collide_blk_q", bus.blk_q, m_blk);
        check("collide_key_q", bus.key_q, m_key);
        check("collide_frame_errs", n_ferr, exp_ferr);
        check("collide_starts", n_start, exp_start);
        run_frame("after_collide", 0, {8{$urandom}}, 128);

        // commits while the core is busy collapse into a single start
        bus.core_busy = 1'b1;
        run_frame("busy_a", 0, {8{$urandom}}, 128);
        run_frame("busy_b", 0, {8{$urandom}}, 128);
        @(negedge clk); bus.core_busy = 1'b0;
        if (m_pending) begin exp_start++; m_pending = 0; end
        idle(4);
        check("busy_starts", n_start, exp_start);
        check("busy_blk_q", bus.blk_q, m_blk);

        // block before any key, then key
        do_reset();
        run_frame("nokey_blk", 0, {8{$urandom}}, 128);
        run_frame("late_key", 1, {8{$urandom}}, 256);

        run_frame("over130", 0, {8{$urandom}}, 130);

        for (int k = 0; k < 6; k++) begin
            bit is_key;
            int w;
            int ne;
            is_key = 1'($urandom);
            w  = is_key ? 256 : 128;
            ne = ($urandom_range(0, 3) == 0) ? $urandom_range(1, w - 1) : w;
            d  = {8{$urandom}};
            for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
            run_frame("rand", is_key, d, ne);
        end

        // reset in the middle of a key frame
        @(negedge clk); bus.cs_key = 1'b0;
        repeat (100) begin @(negedge clk); bus.mosi = 1'($urandom); end
        #2 rst = 1'b1;
        #1;
        check("midrst_blk_q", bus.blk_q, 0);
        check("midrst_key_q", bus.key_q, 0);
        check("midrst_key_valid", bus.key_valid, 0);
        check("midrst_start", bus.start, 0);
        check("midrst_frame_err", bus.frame_err, 0);
        bus.cs_key = 1'b1;
        n_ferr = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        idle(3);
        check("postrst_key_valid", bus.key_valid, 0);
        check("postrst_frame_errs", n_ferr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
